// File: rtl/jk_pkg.sv
// Shared encodings and the JK next-state helper for the jk_ff_bank slice.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_e;

   function automatic logic jk_next(input logic q, input logic j, input logic k);
      jk_op_e op;
      logic   nq;
      op = jk_op_e'({j, k});
      case (op)
         JK_HOLD:   nq = q;
         JK_RESET:  nq = 1'b0;
         JK_SET:    nq = 1'b1;
         JK_TOGGLE: nq = ~q;
         default:   nq = q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/jk_ff_bank_if.sv
// Channel-side signal bundle of jk_ff_bank: JK/enable/load inputs and state/timing outputs.
interface jk_ff_bank_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] iJ;
   logic [WIDTH-1:0] iK;
   logic [WIDTH-1:0] iEn;
   logic             iLoad;
   logic [WIDTH-1:0] iLoadData;
   logic [WIDTH-1:0] oQ;
   logic [WIDTH-1:0] oQ_bar;
   logic             oClkDiv;
   logic             oTick;

   modport master (
      output iJ, iK, iEn, iLoad, iLoadData,
      input  oQ, oQ_bar, oClkDiv, oTick
   );

   modport slave (
      input  iJ, iK, iEn, iLoad, iLoadData,
      output oQ, oQ_bar, oClkDiv, oTick
   );
endinterface

// File: rtl/clk_div_en.sv
// Period counter producing a one-cycle update strobe and a divided square wave for display.
module clk_div_en #(
   parameter int DIV = 10
) (
   input  logic iClk,
   input  logic iReset_n,
   output logic oTick,
   output logic oClkDiv
);
   localparam int               CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((DIV + 1) / 2);

   if (DIV < 2) begin : g_bad_div
      $error("clk_div_en: DIV must be at least 2");
   end

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;

   // Wrap at DIV-1 so the wrap edge is also the update edge.
   always_comb begin
      cnt_next_s = cnt_r;
      if (cnt_r == CNT_MAX) begin
         cnt_next_s = '0;
      end else begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end
   end

   // Period counter register.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

   assign oTick   = (cnt_r == CNT_MAX);
   assign oClkDiv = (cnt_r >= CNT_HALF);

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH JK channels updated on a shared divided tick, with per-channel enable and parallel load.
// Optional macro INPUT_SYNC_EN adds 2-flop synchronizers on iJ, iK and iEn.
module jk_ff_bank
   import jk_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 10
) (
   input  logic          iClk,
   input  logic          iReset_n,
   jk_ff_bank_if.slave   bus
);
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("jk_ff_bank: WIDTH must be within 1..32");
   end

   logic             tick_s;
   logic             clk_div_s;
   logic [WIDTH-1:0] j_s;
   logic [WIDTH-1:0] k_s;
   logic [WIDTH-1:0] en_s;
   logic [WIDTH-1:0] q_s;

   clk_div_en #(
      .DIV (DIV)
   ) u_clk_div_en (
      .iClk     (iClk),
      .iReset_n (iReset_n),
      .oTick    (tick_s),
      .oClkDiv  (clk_div_s)
   );

`ifdef INPUT_SYNC_EN
   logic [WIDTH-1:0] j_meta_r;
   logic [WIDTH-1:0] k_meta_r;
   logic [WIDTH-1:0] en_meta_r;
   logic [WIDTH-1:0] j_sync_r;
   logic [WIDTH-1:0] k_sync_r;
   logic [WIDTH-1:0] en_sync_r;

   // Two-stage synchronizers; a tick sees the inputs from two edges earlier.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         j_meta_r  <= '0;
         k_meta_r  <= '0;
         en_meta_r <= '0;
         j_sync_r  <= '0;
         k_sync_r  <= '0;
         en_sync_r <= '0;
      end else begin
         j_meta_r  <= bus.iJ;
         k_meta_r  <= bus.iK;
         en_meta_r <= bus.iEn;
         j_sync_r  <= j_meta_r;
         k_sync_r  <= k_meta_r;
         en_sync_r <= en_meta_r;
      end
   end

   assign j_s  = j_sync_r;
   assign k_s  = k_sync_r;
   assign en_s = en_sync_r;
`else
   assign j_s  = bus.iJ;
   assign k_s  = bus.iK;
   assign en_s = bus.iEn;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic q_r;
      logic q_next_s;

      // Load overrides the tick update; disabled channels and non-tick cycles hold.
      always_comb begin
         q_next_s = q_r;
         if (bus.iLoad) begin
            q_next_s = bus.iLoadData[i];
         end else if (tick_s && en_s[i]) begin
            q_next_s = jk_next(q_r, j_s[i], k_s[i]);
         end else begin
            q_next_s = q_r;
         end
      end

      // Channel state register.
      always_ff @(posedge iClk or negedge iReset_n) begin
         if (!iReset_n) begin
            q_r <= 1'b0;
         end else begin
            q_r <= q_next_s;
         end
      end

      assign q_s[i] = q_r;
   end

   // oQ_bar derives from the same register so it can never disagree with oQ.
   assign bus.oQ      = q_s;
   assign bus.oQ_bar  = ~q_s;
   assign bus.oTick   = tick_s;
   assign bus.oClkDiv = clk_div_s;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Scoreboard bench for jk_ff_bank (WIDTH=4, DIV=10); honours INPUT_SYNC_EN when defined.
module tb_jk_ff_bank;
   localparam int WIDTH = 4;
   localparam int DIV   = 10;

   typedef struct packed {
      logic [3:0] q;
      logic       tick;
      logic       clkdiv;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   exp_t sb[$];
   int   m_cnt;
   logic [3:0] m_q;
`ifdef INPUT_SYNC_EN
   logic [3:0] m_j1, m_j2, m_k1, m_k2, m_e1, m_e2;
`endif

   jk_ff_bank_if #(.WIDTH(WIDTH)) bus ();

   jk_ff_bank #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .iClk     (clk),
      .iReset_n (rst_n),
      .bus      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic string fmt_obs();
      return $sformatf("q=%h qb=%h tick=%b div=%b", bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv);
   endfunction

   function automatic string fmt_exp(input exp_t e);
      return $sformatf("q=%h qb=%h tick=%b div=%b", e.q, ~e.q, e.tick, e.clkdiv);
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_q   = 4'h0;
      sb.delete();
`ifdef INPUT_SYNC_EN
      m_j1 = 4'h0; m_j2 = 4'h0; m_k1 = 4'h0; m_k2 = 4'h0; m_e1 = 4'h0; m_e2 = 4'h0;
`endif
   endtask

   // Predict the outcome of the coming edge from the driven inputs, queue it, then take the edge.
   task automatic drive_edge();
      logic [3:0] jj, kk, ee;
      logic       tick;
      exp_t       e;
`ifdef INPUT_SYNC_EN
      jj = m_j2; kk = m_k2; ee = m_e2;
      m_j2 = m_j1; m_k2 = m_k1; m_e2 = m_e1;
      m_j1 = bus.iJ; m_k1 = bus.iK; m_e1 = bus.iEn;
`else
      jj = bus.iJ; kk = bus.iK; ee = bus.iEn;
`endif
      tick = (m_cnt == DIV - 1);
      if (bus.iLoad) begin
         m_q = bus.iLoadData;
      end else if (tick) begin
         m_q = (ee & ((jj & ~m_q) | (~kk & m_q))) | (~ee & m_q);
      end
      m_cnt    = tick ? 0 : m_cnt + 1;
      e.q      = m_q;
      e.tick   = (m_cnt == DIV - 1);
      e.clkdiv = (m_cnt >= (DIV + 1) / 2);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      int   first_tick;
      rst_n = 1'b0;
      bus.iJ = 4'hF; bus.iK = 4'hF; bus.iEn = 4'hF;
      bus.iLoad = 1'b0; bus.iLoadData = 4'h0;
      for (int c = 0; c < 17; c++) begin
         @(posedge clk);
         #1;
         n_vec++;
         if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {4'h0, 4'hF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold cycle %0d: got %s, want q=0 qb=f tick=0 div=0", c, fmt_obs());
         end
      end
      rst_n = 1'b1;
      model_reset();
      first_tick = -1;
      for (int c = 0; c < DIV; c++) begin
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {e.q, ~e.q, e.tick, e.clkdiv}) begin
            n_err++;
            $display("FAIL reset_release edge %0d: got %s, want %s", c + 1, fmt_obs(), fmt_exp(e));
         end
         if (bus.oTick === 1'b1 && first_tick < 0) first_tick = c + 1;
      end
      n_vec++;
      if (first_tick != DIV - 1 || bus.oQ !== 4'hF) begin
         n_err++;
         $display("FAIL first_update: tick after edge %0d q=%h, want edge %0d q=f", first_tick, bus.oQ, DIV - 1);
      end
   endtask

   task automatic test_jk_update();
      exp_t e;
      int   ticks;
      ticks = 0;
      for (int c = 0; c < 2 * DIV; c++) begin
         bus.iLoad = (c == 2);
         bus.iLoadData = 4'b0110;
         if (c >= 3) begin
            bus.iJ = 4'b1100; bus.iK = 4'b1010; bus.iEn = 4'hF;
         end
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {e.q, ~e.q, e.tick, e.clkdiv}) begin
            n_err++;
            $display("FAIL jk_update cycle %0d: got %s, want %s", c, fmt_obs(), fmt_exp(e));
         end
         if (bus.oTick === 1'b1) ticks++;
         if (c == DIV - 1) begin
            n_vec++;
            if (bus.oQ !== 4'b1100 || bus.oClkDiv !== 1'b0) begin
               n_err++;
               $display("FAIL jk_table: got q=%h div=%b, want q=c div=0", bus.oQ, bus.oClkDiv);
            end
         end
      end
      n_vec++;
      if (ticks != 2) begin
         n_err++;
         $display("FAIL tick_rate: got %0d ticks in %0d cycles, want 2", ticks, 2 * DIV);
      end
   endtask

   task automatic test_enable();
      exp_t e;
      for (int c = 0; c < DIV; c++) begin
         bus.iLoad = (c == 0);
         bus.iLoadData = 4'h0;
         bus.iEn = 4'b0101;
         bus.iJ = (c < 5) ? 4'($urandom_range(0, 15)) : 4'hF;
         bus.iK = (c < 5) ? 4'($urandom_range(0, 15)) : 4'hF;
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {e.q, ~e.q, e.tick, e.clkdiv}) begin
            n_err++;
            $display("FAIL enable cycle %0d: got %s, want %s", c, fmt_obs(), fmt_exp(e));
         end
      end
      n_vec++;
      if (bus.oQ !== 4'b0101) begin
         n_err++;
         $display("FAIL enable_mask: got q=%h, want 5", bus.oQ);
      end
   endtask

   task automatic test_load();
      exp_t e;
      bus.iJ = 4'hF; bus.iK = 4'hF; bus.iEn = 4'hF;
      for (int c = 0; c < DIV; c++) begin
         bus.iLoad = (c == 4) || (c == DIV - 1);
         bus.iLoadData = 4'h9;
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {e.q, ~e.q, e.tick, e.clkdiv}) begin
            n_err++;
            $display("FAIL load cycle %0d: got %s, want %s", c, fmt_obs(), fmt_exp(e));
         end
         if (c == 4 || c == DIV - 1) begin
            n_vec++;
            if (bus.oQ !== 4'h9) begin
               n_err++;
               $display("FAIL load_value cycle %0d: got q=%h, want 9", c, bus.oQ);
            end
         end
      end
      bus.iLoad = 1'b0;
   endtask

   task automatic test_async_reset();
      exp_t e;
      bus.iJ = 4'h0; bus.iK = 4'h0; bus.iEn = 4'hF;
      for (int c = 0; c < 7; c++) begin
         bus.iLoad = (c == 0);
         bus.iLoadData = 4'hA;
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {e.q, ~e.q, e.tick, e.clkdiv}) begin
            n_err++;
            $display("FAIL pre_reset cycle %0d: got %s, want %s", c, fmt_obs(), fmt_exp(e));
         end
      end
      bus.iLoad = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {4'h0, 4'hF, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL async_reset: got %s, want q=0 qb=f tick=0 div=0", fmt_obs());
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      bus.iJ = 4'hF; bus.iK = 4'hF;
      for (int c = 0; c < DIV; c++) begin
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {e.q, ~e.q, e.tick, e.clkdiv}) begin
            n_err++;
            $display("FAIL post_reset cycle %0d: got %s, want %s", c, fmt_obs(), fmt_exp(e));
         end
      end
      n_vec++;
      if (bus.oQ !== 4'hF) begin
         n_err++;
         $display("FAIL post_reset_update: got q=%h, want f", bus.oQ);
      end
   endtask

`ifdef INPUT_SYNC_EN
   task automatic test_input_sync();
      exp_t e;
      for (int c = 0; c < 2 * DIV; c++) begin
         bus.iLoad = (c == 0);
         bus.iLoadData = 4'h0;
         bus.iEn = 4'hF;
         if (c == DIV - 2 || c == 2 * DIV - 3) begin
            bus.iJ = 4'hF; bus.iK = 4'h0;
         end else if (c == 0 || c == DIV) begin
            bus.iJ = 4'h0; bus.iK = 4'h0;
         end
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if ({bus.oQ, bus.oQ_bar, bus.oTick, bus.oClkDiv} !== {e.q, ~e.q, e.tick, e.clkdiv}) begin
            n_err++;
            $display("FAIL sync cycle %0d: got %s, want %s", c, fmt_obs(), fmt_exp(e));
         end
         if (c == DIV - 1 || c == 2 * DIV - 1) begin
            n_vec++;
            if (bus.oQ !== ((c == DIV - 1) ? 4'h0 : 4'hF)) begin
               n_err++;
               $display("FAIL sync_latency cycle %0d: got q=%h", c, bus.oQ);
            end
         end
      end
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      test_reset();
      test_jk_update();
      test_enable();
      test_load();
      test_async_reset();
`ifdef INPUT_SYNC_EN
      test_input_sync();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
